// File: rtl/branch_resolve_queue_if.sv
// Fetch/execute-side bus of the branch resolve queue: predicted-branch push,
// in-order resolution, and the registered predictor-update/redirect outputs.
interface branch_resolve_queue_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 14
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             pred_valid;
    logic [PC_W-1:0]  pred_pc;
    logic             pred_taken;
    logic [PC_W-1:0]  pred_target;
    logic             pred_ready;
    logic             res_valid;
    logic             res_taken;
    logic [PC_W-1:0]  res_target;
    logic             branch_en;
    logic             branch_result;
    logic [PC_W-1:0]  upd_pc;
    logic             mispredict;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] count;
    logic             res_error;

    modport master (
        output pred_valid, pred_pc, pred_taken, pred_target,
        output res_valid, res_taken, res_target,
        input  pred_ready, branch_en, branch_result, upd_pc,
        input  mispredict, redirect_pc, count, res_error
    );

    modport slave (
        input  pred_valid, pred_pc, pred_taken, pred_target,
        input  res_valid, res_taken, res_target,
        output pred_ready, branch_en, branch_result, upd_pc,
        output mispredict, redirect_pc, count, res_error
    );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of predicted branches; compares each resolution against the
// oldest prediction, emits the predictor update and flushes on mispredict.
module branch_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 14
) (
    input logic                   clk,
    input logic                   rst,
    branch_resolve_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  pc_mem  [DEPTH];
    logic [PC_W-1:0]  tgt_mem [DEPTH];
    logic [DEPTH-1:0] taken_mem;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] cnt;

    logic             ready;
    logic             push;
    logic             pop;
    logic             mis;
    logic [PC_W-1:0]  head_pc;
    logic [PC_W-1:0]  head_tgt;
    logic             head_taken;

    assign ready      = (cnt != CNT_W'(DEPTH));
    assign push       = bus.pred_valid && ready;
    assign pop        = bus.res_valid && (cnt != '0);
    assign head_pc    = pc_mem[head];
    assign head_tgt   = tgt_mem[head];
    assign head_taken = taken_mem[head];
    assign mis        = pop && ((head_taken != bus.res_taken) ||
                                (head_taken && bus.res_taken && (head_tgt != bus.res_target)));

    assign bus.pred_ready = ready;
    assign bus.count      = cnt;

    // Entry storage is not reset; a write past a flush is harmless since tail is not advanced.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail]    <= bus.pred_pc;
            tgt_mem[tail]   <= bus.pred_target;
            taken_mem[tail] <= bus.pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head              <= '0;
            tail              <= '0;
            cnt               <= '0;
            bus.branch_en     <= 1'b0;
            bus.branch_result <= 1'b0;
            bus.upd_pc        <= '0;
            bus.mispredict    <= 1'b0;
            bus.redirect_pc   <= '0;
            bus.res_error     <= 1'b0;
        end else begin
            bus.branch_en  <= pop;
            bus.mispredict <= mis;
            bus.res_error  <= bus.res_valid && (cnt == '0);
            if (pop) begin
                bus.branch_result <= bus.res_taken;
                bus.upd_pc        <= head_pc;
            end
            if (mis) begin
                bus.redirect_pc <= bus.res_taken ? bus.res_target : head_pc + PC_W'(4);
                head            <= '0;
                tail            <= '0;
                cnt             <= '0;
            end else begin
                if (push) tail <= tail + 1'b1;
                if (pop)  head <= head + 1'b1;
                cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Randomized and directed bench for branch_resolve_queue against a queue-based
// reference model of in-flight predictions.
module tb_branch_resolve_queue;
    localparam int DEPTH = 4;
    localparam int PC_W  = 14;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic [PC_W-1:0] tgt;
    } ent_t;

    logic clk;
    logic rst;

    branch_resolve_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

    branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks;
    int unsigned n_fail;

    ent_t q[$];
    logic            e_en, e_res, e_mis, e_err;
    logic [PC_W-1:0] e_upd, e_redir;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic pv, input logic [PC_W-1:0] ppc,
                        input logic pt, input logic [PC_W-1:0] ptgt,
                        input logic rv, input logic rt, input logic [PC_W-1:0] rtgt);
        ent_t h;
        bit   full;
        bit   popped;
        bit   wrong;
        rst             = r;
        bus.pred_valid  = pv;
        bus.pred_pc     = ppc;
        bus.pred_taken  = pt;
        bus.pred_target = ptgt;
        bus.res_valid   = rv;
        bus.res_taken   = rt;
        bus.res_target  = rtgt;
        if (!r) begin
            q.delete();
            e_en = 0; e_res = 0; e_upd = '0; e_mis = 0; e_redir = '0; e_err = 0;
        end else begin
            full   = (q.size() == DEPTH);
            popped = rv && (q.size() > 0);
            wrong  = 0;
            e_err  = rv && (q.size() == 0);
            e_en   = popped;
            if (popped) begin
                h     = q[0];
                e_res = rt;
                e_upd = h.pc;
                wrong = (h.taken != rt) || (h.taken && rt && h.tgt != rtgt);
                if (wrong)
                    e_redir = rt ? rtgt : PC_W'((int'(h.pc) + 4) % (1 << PC_W));
            end
            e_mis = wrong;
            if (wrong) q.delete();
            else begin
                if (popped) void'(q.pop_front());
                if (pv && !full) q.push_back('{pc: ppc, taken: pt, tgt: ptgt});
            end
        end
        @(posedge clk);
        #1;
        check("branch_en", 32'(bus.branch_en), 32'(e_en));
        check("branch_result", 32'(bus.branch_result), 32'(e_res));
        check("upd_pc", 32'(bus.upd_pc), 32'(e_upd));
        check("mispredict", 32'(bus.mispredict), 32'(e_mis));
        check("redirect_pc", 32'(bus.redirect_pc), 32'(e_redir));
        check("res_error", 32'(bus.res_error), 32'(e_err));
        check("count", 32'(bus.count), q.size());
        check("pred_ready", 32'(bus.pred_ready), 32'(q.size() != DEPTH));
    endtask

    task automatic idle();
        step(1, 0, '0, 0, '0, 0, 0, '0);
    endtask

    task automatic push(input logic [PC_W-1:0] pc, input logic t, input logic [PC_W-1:0] tgt);
        step(1, 1, pc, t, tgt, 0, 0, '0);
    endtask

    task automatic resolve(input logic t, input logic [PC_W-1:0] tgt);
        step(1, 0, '0, 0, '0, 1, t, tgt);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        // Reset state, then correct taken prediction.
        step(0, 1, 14'h0AA, 1, 14'h0BB, 1, 1, 14'h0BB);
        check("reset_count", 32'(bus.count), 0);
        check("reset_ready", 32'(bus.pred_ready), 1);
        push(14'h00A, 1, 14'h040);
        resolve(1, 14'h040);
        check("d033_en", 32'(bus.branch_en), 1);
        check("d033_upd", 32'(bus.upd_pc), 32'h00A);
        check("d033_mis", 32'(bus.mispredict), 0);
        idle();
        check("hold_en_low", 32'(bus.branch_en), 0);

        // Not-taken predicted, taken actual.
        push(14'h01F, 0, 14'h000);
        resolve(1, 14'h100);
        check("d034_mis", 32'(bus.mispredict), 1);
        check("d034_redir", 32'(bus.redirect_pc), 32'h100);

        // Taken predicted, not-taken actual at top of PC space: fall-through wraps.
        push(14'h3FFC, 1, 14'h123);
        resolve(0, 14'h055);
        check("d035_mis", 32'(bus.mispredict), 1);
        check("d035_redir", 32'(bus.redirect_pc), 0);

        // Taken with wrong target.
        push(14'h200, 1, 14'h300);
        resolve(1, 14'h304);
        check("target_mis_redir", 32'(bus.redirect_pc), 32'h304);

        // Fill, overflow, pop+push while full, then pop.
        for (int unsigned i = 0; i < DEPTH; i++) push(14'(16 * i + 1), 0, '0);
        check("full_count", 32'(bus.count), DEPTH);
        check("full_ready", 32'(bus.pred_ready), 0);
        push(14'h3AB, 1, 14'h111);
        check("overflow_count", 32'(bus.count), DEPTH);
        step(1, 1, 14'h3CD, 0, '0, 1, 0, '0);
        check("full_poppush_count", 32'(bus.count), DEPTH - 1);
        resolve(0, '0);
        check("pop_count", 32'(bus.count), DEPTH - 2);
        check("pop_ready", 32'(bus.pred_ready), 1);
        resolve(0, '0);
        resolve(0, '0);

        // Three queued, oldest mispredicts with a same-cycle push.
        push(14'h010, 1, 14'h020);
        push(14'h014, 0, '0);
        push(14'h018, 0, '0);
        step(1, 1, 14'h01C, 0, '0, 1, 0, '0);
        check("flush_count", 32'(bus.count), 0);
        resolve(1, 14'h001);
        check("empty_res_error", 32'(bus.res_error), 1);
        check("empty_res_en", 32'(bus.branch_en), 0);

        // Empty resolve with same-cycle push.
        step(1, 1, 14'h0C0, 0, '0, 1, 0, '0);
        check("empty_push_count", 32'(bus.count), 1);
        resolve(0, '0);

        // Reset mid-stream.
        push(14'h0E0, 1, 14'h0F0);
        push(14'h0E4, 1, 14'h0F4);
        step(0, 1, 14'h0E8, 0, '0, 1, 0, '0);
        check("midrst_count", 32'(bus.count), 0);
        check("midrst_ready", 32'(bus.pred_ready), 1);
        check("midrst_en", 32'(bus.branch_en), 0);

        // Randomized traffic, biased toward correct predictions.
        for (int unsigned i = 0; i < 1500; i++) begin
            logic            r, pv, pt, rv, rt;
            logic [PC_W-1:0] ppc, ptgt, rtgt;
            r    = ($urandom_range(99) != 0);
            pv   = ($urandom_range(9) < 6);
            ppc  = PC_W'($urandom);
            if ($urandom_range(7) == 0) ppc = 14'h3FFC + PC_W'($urandom_range(3));
            pt   = 1'($urandom);
            ptgt = PC_W'($urandom);
            rv   = ($urandom_range(9) < 4);
            rt   = 1'($urandom);
            rtgt = PC_W'($urandom);
            if (q.size() > 0 && $urandom_range(9) < 7) begin
                rt = q[0].taken;
                if ($urandom_range(9) < 8) rtgt = q[0].tgt;
            end
            step(r, pv, ppc, pt, ptgt, rv, rt, rtgt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
